// File: rtl/temp_display.sv
// Shows an 8-bit value on a 4-digit multiplexed common-anode 7-segment display,
// converting binary to BCD with a sequential double-dabble. Macro: TEMP_DISPLAY_SIGNED_EN.
module temp_display #(
  parameter logic [31:0] FREQ_CLK   = 32'd100000000,
  parameter logic [31:0] REFRESH_HZ = 32'd1000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Temp,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Conv_Busy
);

  localparam int unsigned DIGIT_TICKS = int'(FREQ_CLK / REFRESH_HZ);
  localparam int unsigned REF_W       = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned SR_W        = 20;
  localparam logic [6:0]  SEG_BLANK   = 7'h7F;
  localparam logic [6:0]  SEG_MINUS   = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        temp_q, last, last_nxt, mag;
  logic [SR_W-1:0]   sr, sr_nxt, sr_adj;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [3:0]        hund, tens, units, hund_nxt, tens_nxt, units_nxt;
  logic [REF_W-1:0]  ref_cnt;
  logic [1:0]        scan_idx;
  logic [6:0]        seg_c;
  logic [3:0]        an_c;
`ifdef TEMP_DISPLAY_SIGNED_EN
  logic              sign_pend, sign_pend_nxt, sign_disp, sign_disp_nxt;
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Converter input: two's complement magnitude (-128 -> 128) or raw value
`ifdef TEMP_DISPLAY_SIGNED_EN
  assign mag = temp_q[7] ? 8'(~temp_q + 8'd1) : temp_q;
`else
  assign mag = temp_q;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath updates for the double-dabble converter
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    sr_nxt      = sr;
    bit_cnt_nxt = bit_cnt;
    hund_nxt    = hund;
    tens_nxt    = tens;
    units_nxt   = units;
`ifdef TEMP_DISPLAY_SIGNED_EN
    sign_pend_nxt = sign_pend;
    sign_disp_nxt = sign_disp;
`endif
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[8+4*i +: 4] >= 4'd5) sr_adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (temp_q != last) begin
          sr_nxt      = {12'd0, mag};
          last_nxt    = temp_q;
          bit_cnt_nxt = 3'd0;
`ifdef TEMP_DISPLAY_SIGNED_EN
          sign_pend_nxt = temp_q[7];
`endif
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        sr_nxt      = {sr_adj[SR_W-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        hund_nxt  = sr[19:16];
        tens_nxt  = sr[15:12];
        units_nxt = sr[11:8];
`ifdef TEMP_DISPLAY_SIGNED_EN
        sign_disp_nxt = sign_pend;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      temp_q  <= 8'd0;
      last    <= 8'd0;
      sr      <= '0;
      bit_cnt <= 3'd0;
      hund    <= 4'd0;
      tens    <= 4'd0;
      units   <= 4'd0;
`ifdef TEMP_DISPLAY_SIGNED_EN
      sign_pend <= 1'b0;
      sign_disp <= 1'b0;
`endif
    end else begin
      temp_q  <= Temp;
      last    <= last_nxt;
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt_nxt;
      hund    <= hund_nxt;
      tens    <= tens_nxt;
      units   <= units_nxt;
`ifdef TEMP_DISPLAY_SIGNED_EN
      sign_pend <= sign_pend_nxt;
      sign_disp <= sign_disp_nxt;
`endif
    end
  end

  // Refresh counter and digit scan index
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ref_cnt  <= '0;
      scan_idx <= 2'd0;
    end else if (ref_cnt == REF_W'(DIGIT_TICKS - 1)) begin
      ref_cnt  <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      ref_cnt  <= ref_cnt + REF_W'(1);
    end
  end

  // Digit decode with leading-zero suppression
  always_comb begin
    seg_c = SEG_BLANK;
    an_c  = ~(4'b0001 << scan_idx);
    case (scan_idx)
      2'd0: seg_c = seg_code(units);
      2'd1: if (hund != 4'd0 || tens != 4'd0) seg_c = seg_code(tens);
      2'd2: if (hund != 4'd0) seg_c = seg_code(hund);
      default: begin
`ifdef TEMP_DISPLAY_SIGNED_EN
        if (sign_disp) seg_c = SEG_MINUS;
`endif
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Seg       <= SEG_BLANK;
      An        <= 4'hF;
      Conv_Busy <= 1'b0;
    end else begin
      Seg       <= seg_c;
      An        <= an_c;
      Conv_Busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_temp_display.sv
// Directed bench for temp_display: reset/scan, conversion latency, blanking,
// back-to-back updates and reset mid-conversion (DIGIT_TICKS = 4).
module tb_temp_display;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] Temp;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Conv_Busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic       busy_log [0:31];
  logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg42  [4] = '{7'h24, 7'h19, 7'h7F, 7'h7F};

`ifdef TEMP_DISPLAY_SIGNED_EN
  localparam logic [7:0] RST_VAL = 8'd120;
`else
  localparam logic [7:0] RST_VAL = 8'd200;
`endif

  temp_display #(.FREQ_CLK(32'd1000), .REFRESH_HZ(32'd250)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Temp(Temp),
    .Seg(Seg), .An(An), .Conv_Busy(Conv_Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Wait for each anode in turn and compare its segment pattern
  task automatic show(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp_t [4];
    exp_t = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      bit found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge Clk);
        if (An == an_tbl[k]) found = 1'b1;
      end
      if (!found) check($sformatf("%s_an%0d", tag, k), An, an_tbl[k]);
      else        check($sformatf("%s_d%0d", tag, k), Seg, exp_t[k]);
    end
  endtask

  function automatic int digit_of(input logic [3:0] an);
    case (an)
      4'hE:    digit_of = 0;
      4'hD:    digit_of = 1;
      4'hB:    digit_of = 2;
      default: digit_of = 3;
    endcase
  endfunction

  initial begin
    Rst_n = 1'b0;
    Temp  = 8'd0;
    repeat (2) @(negedge Clk);
    check("rst_seg", Seg, 7'h7F);
    check("rst_an", An, 4'hF);
    check("rst_busy", Conv_Busy, 1'b0);
    Rst_n = 1'b1;

    // Scan with Temp=0: each anode 4 cycles, only units shows "0"
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      check($sformatf("scan_an%0d", i), An, an_tbl[i/4]);
      check($sformatf("scan_seg%0d", i), Seg, (i < 4) ? 7'h40 : 7'h7F);
      check($sformatf("scan_busy%0d", i), Conv_Busy, 1'b0);
    end

    Temp = 8'd5;
    repeat (14) @(negedge Clk);
    show("v5", 7'h7F, 7'h7F, 7'h7F, 7'h12);

    // 42 then 99 four cycles later: two back-to-back conversions
    Temp = 8'd42;
    busy_log[0] = Conv_Busy;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      busy_log[k] = Conv_Busy;
      if (k == 4) Temp = 8'd99;
      if (k >= 12 && k <= 21) check($sformatf("v42_k%0d", k), Seg, seg42[digit_of(An)]);
    end
    begin
      int pulses = 0;
      for (int k = 1; k <= 30; k++) if (busy_log[k] && !busy_log[k-1]) pulses++;
      check("b2b_pulses", pulses, 2);
    end
    check("b2b_busy1", busy_log[1], 1'b0);
    check("b2b_busy2", busy_log[2], 1'b1);
    check("b2b_busy11", busy_log[11], 1'b0);
    check("b2b_busy12", busy_log[12], 1'b1);
    check("b2b_busy20", busy_log[20], 1'b1);
    check("b2b_busy21", busy_log[21], 1'b0);
    show("v99", 7'h7F, 7'h7F, 7'h10, 7'h10);

`ifdef TEMP_DISPLAY_SIGNED_EN
    Temp = 8'hF6;
    repeat (13) @(negedge Clk);
    show("vm10", 7'h3F, 7'h7F, 7'h79, 7'h40);
    Temp = 8'h80;
    repeat (13) @(negedge Clk);
    show("vm128", 7'h3F, 7'h79, 7'h24, 7'h00);
`else
    Temp = 8'd173;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      busy_log[k] = Conv_Busy;
    end
    check("c173_busy1", busy_log[1], 1'b0);
    check("c173_busy2", busy_log[2], 1'b1);
    check("c173_busy10", busy_log[10], 1'b1);
    check("c173_busy11", busy_log[11], 1'b0);
    show("v173", 7'h7F, 7'h79, 7'h78, 7'h30);
`endif

    // Reset at shift count 4, then reconversion of the held value
    Temp = RST_VAL;
    repeat (6) @(negedge Clk);
    check("mid_busy", Conv_Busy, 1'b1);
    Rst_n = 1'b0;
    #1;
    check("mid_rst_seg", Seg, 7'h7F);
    check("mid_rst_an", An, 4'hF);
    check("mid_rst_busy", Conv_Busy, 1'b0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      busy_log[k] = Conv_Busy;
    end
    check("rc_busy1", busy_log[1], 1'b0);
    check("rc_busy2", busy_log[2], 1'b1);
    check("rc_busy10", busy_log[10], 1'b1);
    check("rc_busy11", busy_log[11], 1'b0);
`ifdef TEMP_DISPLAY_SIGNED_EN
    show("vrst", 7'h7F, 7'h79, 7'h24, 7'h40);
`else
    show("vrst", 7'h7F, 7'h24, 7'h40, 7'h40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
